uart_frame_tx: RTL and testbench
================================

UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have one clock, `clk`, and one reset, `reset`, which is asynchronous and active-high.
REQ-002 SHALL take these parameters (name, default, meaning):
- CLKS_PER_BIT, 20, clk cycles per serial bit (400 ns at a 20 ns clk).
- FIFO_DEPTH, 4, transmit buffer entries, power of two, at least 2.
- STOP_BITS, 2, stop bits per frame (1 or 2).
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- data, in, 8, byte to transmit.
- send, in, 1, one-cycle write strobe that pushes `data`.
- full, out, 1, buffer holds FIFO_DEPTH bytes.
- busy, out, 1, frame in progress or buffer non-empty.
- overflow, out, 1, sticky flag: a push was dropped.
- tx_o, out, 1, serial line, idle high.

Function
REQ-004 Frame SHALL be: start bit (0), 8 data bits LSB first, even parity bit, STOP_BITS stop bits (1).
REQ-005 Parity bit SHALL be the XOR of the 8 data bits, so the total count of 1s in data plus parity is even.
REQ-006 Each bit SHALL hold tx_o for exactly CLKS_PER_BIT cycles; a full frame is (10+STOP_BITS)*CLKS_PER_BIT cycles, 240 at defaults.
REQ-007 tx_o SHALL be driven straight from a register with no combinational path to the output.
REQ-008 FSM states SHALL be IDLE, START, DATA, PARITY and STOP. Transitions:
- IDLE -> START when the buffer is non-empty.
- START -> DATA after 1 bit period.
- DATA -> PARITY after 8 bit periods.
- PARITY -> STOP after 1 bit period.
- STOP -> START after STOP_BITS bit periods if the buffer is non-empty, otherwise STOP -> IDLE.
REQ-009 The buffer pop and the load of the shift register SHALL happen on the clock edge that enters START.
REQ-010 A back-to-back frame SHALL start with no idle gap after the last stop bit.
REQ-011 Latency: with the FSM in IDLE and the buffer empty, `send` sampled at edge k SHALL give tx_o=0 after edge k+1.
REQ-012 A push SHALL be accepted iff send=1 and full=0.
REQ-013 A push with send=1 and full=1 SHALL be dropped and SHALL set overflow, which holds until reset. This applies even if a pop occurs in the same cycle.
REQ-014 A simultaneous push and pop when not full SHALL both occur, leaving the occupancy unchanged.
REQ-015 Buffer pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be held in log2(FIFO_DEPTH)+1 bits; full is occupancy==FIFO_DEPTH.
REQ-016 busy SHALL be 1 whenever the FSM is not in IDLE or occupancy is non-zero. busy is combinational from registers.
REQ-017 `data` SHALL be captured at push time, so later changes to `data` do not affect queued bytes.
REQ-018 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and reload on every bit boundary, with no drift across frames.

Reset
REQ-019 Reset SHALL asynchronously force tx_o=1, busy=0, full=0 and overflow=0, the FSM to IDLE, and all counters and pointers to 0.
REQ-020 Reset during a frame SHALL abort it immediately and discard all buffered bytes, with no partial frame resumed afterwards.
REQ-021 After reset deasserts, the first push SHALL behave per REQ-011.

Structure
REQ-022 The state encoding and the frame constants (data width 8, parity mode even) SHALL live in a shared package, uart_pkg, which uart_receive also uses.
REQ-023 The buffer SHALL be a sub-module, uart_tx_fifo, with parameters DEPTH and WIDTH=8 and ports push, pop, din, dout, full, empty and count.
REQ-024 The FSM, bit counter, shift register and parity logic SHALL live in uart_frame_tx.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Push 0x1D. Expect tx_o 0 | 1,0,1,1,1,0,0,0 | parity 0 | 1,1, each bit for 20 cycles, and busy to drop at cycle 240 after the start edge.
- Push 0xFF then 0x00 in consecutive cycles. Expect parity 0 for both, the second start bit immediately after the first frame's second stop bit, and total busy time 480 cycles.
- Push 5 bytes in 5 consecutive cycles while IDLE. Expect the first to be popped at cycle 2 and bytes 2-5 to be accepted with no overflow; a 6th push one cycle later, with full=1, is dropped and sets overflow.
- Assert reset 100 cycles into a frame with 2 bytes queued. Expect tx_o=1 immediately, busy=0, and no further frames.
- Loop tx_o into uart_receive with CLKS_PER_BIT=20 and send 0x00, 0x55, 0xA5 and 0xFF. Expect each byte to be received intact with the ready pulse and no parity error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, FSM state encoding and parity helper shared by the UART blocks.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam bit PARITY_ODD = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return ^d ^ PARITY_ODD;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two transmit buffer; a push while full is dropped even when a pop happens alongside.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: buffered 8E1/8E2 UART transmitter with registered serial output.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx_o
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [DATA_BITS-1:0] shreg, shreg_next, fifo_dout;
  logic [AW:0] count;
  logic par, tick, pop, empty, tx_next;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(send),
    .pop(pop),
    .din(data),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );

  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  // Pop and shift-register load coincide with every entry into START, from IDLE or straight from STOP.
  assign pop = state_next == START && state != START;
  assign shreg_next = pop ? fifo_dout : (state == DATA && tick) ? shreg >> 1 : shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      tx_o <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      bit_idx <= state_next != state ? '0 : bit_idx + 3'(tick);
      shreg <= shreg_next;
      if (pop) par <= parity_bit(fifo_dout);
      tx_o <= tx_next;
      overflow <= overflow | (send & full);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = empty ? IDLE : START;
      START:   state_next = tick ? DATA : START;
      DATA:    state_next = (tick && bit_idx == 3'd7) ? PARITY : DATA;
      PARITY:  state_next = tick ? STOP : PARITY;
      STOP:    state_next = (tick && bit_idx == 3'(STOP_BITS - 1)) ? (empty ? IDLE : START) : STOP;
      default: state_next = IDLE;
    endcase
  end

  // The line value is computed for the state being entered so tx_o can be a plain register.
  always_comb begin
    tx_next = state_next == START ? 1'b0 :
              state_next == DATA ? shreg_next[0] :
              state_next == PARITY ? par : 1'b1;
    busy = state != IDLE || count != '0;
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed frame vectors, back-to-back, overflow, reset abort and serial loopback decoding.
module tb_uart_frame_tx;
  logic clk = 0, reset = 0, send = 0, rx_en = 0;
  logic [7:0] data = 8'h00;
  logic full, busy, overflow, tx_o;
  int checks = 0, errors = 0;

  typedef struct {logic [7:0] d; logic [11:0] frame;} vec_t;
  typedef struct {logic [7:0] d; logic ok;} rx_t;
  rx_t rx_q[$];

  uart_frame_tx #(.CLKS_PER_BIT(20), .FIFO_DEPTH(4), .STOP_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .data(data),
    .send(send),
    .full(full),
    .busy(busy),
    .overflow(overflow),
    .tx_o(tx_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial receiver: samples mid-bit after each start edge, checks start, even parity and both stops.
  initial begin : rx_model
    logic [7:0] rd;
    logic rs, rp, r1, r2;
    forever begin
      @(negedge tx_o);
      repeat (10) @(posedge clk);
      #1 rs = tx_o;
      for (int i = 0; i < 8; i++) begin
        repeat (20) @(posedge clk);
        #1 rd[i] = tx_o;
      end
      repeat (20) @(posedge clk);
      #1 rp = tx_o;
      repeat (20) @(posedge clk);
      #1 r1 = tx_o;
      repeat (20) @(posedge clk);
      #1 r2 = tx_o;
      if (rx_en) rx_q.push_back('{rd, !rs && (rp == ^rd) && r1 && r2});
    end
  end

  // Caller sits at the negedge just before the first bit cycle; each bit must hold for 20 cycles.
  task automatic check_bits(input logic [23:0] f, input int n, input string name);
    logic busy_ok;
    busy_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic got;
      got = f[i];
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        send = 0;
        if (tx_o !== f[i]) got = tx_o;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      chk($sformatf("%s bit%0d", name, i), got, f[i]);
    end
    chk({name, " busy_held"}, busy_ok, 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [11:0] f, input string name);
    @(negedge clk);
    data = d;
    send = 1;
    @(negedge clk);
    chk({name, " pre_start"}, tx_o, 1);
    chk({name, " busy_on"}, busy, 1);
    send = 0;
    data = ~d;
    check_bits({12'h000, f}, 12, name);
    @(negedge clk);
    chk({name, " busy_drop"}, busy, 0);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, " idle_in_time"}, n < maxc, 1);
  endtask

  initial begin
    #(20 * 30000);
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] lb [4];
    logic [7:0] ob [5];
    logic held;
    vecs[0] = '{8'h1D, 12'hC3A};
    vecs[1] = '{8'h00, 12'hC00};
    vecs[2] = '{8'hFF, 12'hDFE};
    vecs[3] = '{8'h55, 12'hCAA};
    vecs[4] = '{8'hA5, 12'hD4A};
    vecs[5] = '{8'h01, 12'hE02};
    vecs[6] = '{8'h80, 12'hF00};
    vecs[7] = '{8'h07, 12'hE0E};
    lb = '{8'h00, 8'h55, 8'hA5, 8'hFF};
    ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    #2 reset = 1;
    #3;
    chk("reset tx_o", tx_o, 1);
    chk("reset busy", busy, 0);
    chk("reset full", full, 0);
    chk("reset overflow", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    for (int i = 0; i < 8; i++) send_frame(vecs[i].d, vecs[i].frame, $sformatf("vec%0d", i));

    @(negedge clk);
    data = 8'hFF;
    send = 1;
    @(negedge clk);
    chk("b2b pre_start", tx_o, 1);
    data = 8'h00;
    check_bits(24'hC00DFE, 24, "b2b");
    @(negedge clk);
    chk("b2b busy_drop", busy, 0);

    rx_q.delete();
    rx_en = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = lb[i];
      send = 1;
    end
    @(negedge clk);
    send = 0;
    wait_idle(2000, "loopback");
    rx_en = 0;
    chk("loopback count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) begin
        chk($sformatf("loopback byte%0d", i), rx_q[i].d, lb[i]);
        chk($sformatf("loopback frame_ok%0d", i), rx_q[i].ok, 1);
      end

    rx_q.delete();
    rx_en = 1;
    @(negedge clk);
    data = ob[0];
    send = 1;
    @(negedge clk);
    data = ob[1];
    @(negedge clk);
    chk("ovf pop_at_2", tx_o, 0);
    chk("ovf full_1", full, 0);
    data = ob[2];
    @(negedge clk);
    data = ob[3];
    @(negedge clk);
    chk("ovf full_3", full, 0);
    data = ob[4];
    @(negedge clk);
    chk("ovf full_4", full, 1);
    chk("ovf not_yet", overflow, 0);
    data = 8'h66;
    @(negedge clk);
    send = 0;
    chk("ovf set", overflow, 1);
    chk("ovf still_full", full, 1);
    wait_idle(3000, "ovf");
    rx_en = 0;
    chk("ovf sticky", overflow, 1);
    chk("ovf count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rx_q.size()) begin
        chk($sformatf("ovf byte%0d", i), rx_q[i].d, ob[i]);
        chk($sformatf("ovf frame_ok%0d", i), rx_q[i].ok, 1);
      end

    @(negedge clk);
    data = 8'h00;
    send = 1;
    @(negedge clk);
    data = 8'hFF;
    @(negedge clk);
    data = 8'h0F;
    @(negedge clk);
    send = 0;
    repeat (99) @(negedge clk);
    chk("abort mid_frame tx_o", tx_o, 0);
    chk("abort mid_frame busy", busy, 1);
    reset = 1;
    #1;
    chk("abort tx_o", tx_o, 1);
    chk("abort busy", busy, 0);
    chk("abort full", full, 0);
    chk("abort overflow", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    held = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy !== 1'b0) held = 1'b0;
    end
    chk("abort no_resume", held, 1);

    send_frame(8'h1D, 12'hC3A, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
